// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M multiply FU (MUL/MULH/MULHSU/MULHU) with done/ack CDB handshake.
// Ports: clock, reset; issue_valid/opa/opb/func/rob_tag in, ready out; squash; ack in,
//   done/result/rob_tag_out out. Define MULT_FU_PERF_EN to add perf_ops/perf_stall_cycles.
module mult_fu #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 4,  // >= 1, must divide 2*XLEN
  parameter int TAG_W      = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [XLEN-1:0]  opa,
  input  logic [XLEN-1:0]  opb,
  input  logic [1:0]       func,
  input  logic [TAG_W-1:0] rob_tag,
  input  logic             squash,
  input  logic             ack,
  output logic             ready,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] rob_tag_out
`ifdef MULT_FU_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall_cycles
`endif
);

  localparam int W2    = 2 * XLEN;
  localparam int CHUNK = W2 / NUM_STAGES;

  logic stall;
  logic accept;
  logic sext_a;
  logic sext_b;
  logic [W2-1:0] ext_a;
  logic [W2-1:0] ext_b;

  logic             last_v;
  logic [1:0]       last_func;
  logic [TAG_W-1:0] last_tag;
  logic [W2-1:0]    last_sum;

  logic             done_q, done_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  assign stall  = done_q & ~ack;
  assign ready  = ~stall;
  assign accept = issue_valid & ready;

  // MULHU zero-extends opa; only MUL/MULH sign-extend opb
  assign sext_a = (func != 2'd3);
  assign sext_b = (func == 2'd0) | (func == 2'd1);
  assign ext_a  = {{XLEN{sext_a & opa[XLEN-1]}}, opa};
  assign ext_b  = {{XLEN{sext_b & opb[XLEN-1]}}, opb};

  // Stage k consumes multiplier chunk k; the remaining multiplier
  // shrinks by CHUNK bits per stage so no dead bits are carried.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stg
    localparam int MW = W2 - k * CHUNK;

    logic             v_i;
    logic [1:0]       func_i;
    logic [TAG_W-1:0] tag_i;
    logic [W2-1:0]    mcand_i;
    logic [W2-1:0]    sum_i;
    logic [MW-1:0]    mplier_i;
    logic [W2-1:0]    pp;
    logic [W2-1:0]    sum_o;

    if (k == 0) begin : g_src
      assign v_i      = accept;
      assign func_i   = func;
      assign tag_i    = rob_tag;
      assign mcand_i  = ext_a;
      assign mplier_i = ext_b;
      assign sum_i    = '0;
    end else begin : g_src
      assign v_i      = g_stg[k-1].g_reg.v_q;
      assign func_i   = g_stg[k-1].g_reg.func_q;
      assign tag_i    = g_stg[k-1].g_reg.tag_q;
      assign mcand_i  = g_stg[k-1].g_reg.mcand_q;
      assign mplier_i = g_stg[k-1].g_reg.mplier_q;
      assign sum_i    = g_stg[k-1].g_reg.sum_q;
    end

    assign pp    = mcand_i * W2'(mplier_i[CHUNK-1:0]);
    assign sum_o = sum_i + (pp << (k * CHUNK));

    if (k < NUM_STAGES - 1) begin : g_reg
      logic             v_q, v_d;
      logic [1:0]       func_q, func_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic [W2-1:0]    mcand_q, mcand_d;
      logic [MW-CHUNK-1:0] mplier_q, mplier_d;
      logic [W2-1:0]    sum_q, sum_d;

      always_comb begin
        v_d      = v_q;
        func_d   = func_q;
        tag_d    = tag_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_d    = sum_q;
        if (squash) begin
          v_d = 1'b0;
        end else if (!stall) begin
          v_d      = v_i;
          func_d   = func_i;
          tag_d    = tag_i;
          mcand_d  = mcand_i;
          mplier_d = mplier_i[MW-1:CHUNK];
          sum_d    = sum_o;
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          v_q      <= 1'b0;
          func_q   <= '0;
          tag_q    <= '0;
          mcand_q  <= '0;
          mplier_q <= '0;
          sum_q    <= '0;
        end else begin
          v_q      <= v_d;
          func_q   <= func_d;
          tag_q    <= tag_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          sum_q    <= sum_d;
        end
      end
    end else begin : g_last
      assign last_v    = v_i;
      assign last_func = func_i;
      assign last_tag  = tag_i;
      assign last_sum  = sum_o;
    end
  end

  always_comb begin
    done_d    = done_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    if (squash) begin
      done_d = 1'b0;
    end else if (!stall) begin
      done_d    = last_v;
      tag_out_d = last_tag;
      result_d  = (last_func == 2'd0) ?
                  last_sum[XLEN-1:0] :
                  last_sum[W2-1:XLEN];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q    <= 1'b0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else begin
      done_q    <= done_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign done        = done_q;
  assign result      = result_q;
  assign rob_tag_out = tag_out_q;

`ifdef MULT_FU_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q + 32'(accept);
    perf_stall_d = perf_stall_q + 32'(issue_valid & stall);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops          = perf_ops_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_mult_fu.sv
// tb_mult_fu: random + directed bench for mult_fu against a
// cycle-level reference model using 64-bit integer arithmetic.
module tb_mult_fu;
  localparam int NS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [31:0] opa, opb;
  logic [1:0]  func;
  logic [4:0]  rob_tag;
  logic        squash, ack;
  logic        ready, done;
  logic [31:0] result;
  logic [4:0]  rob_tag_out;
`ifdef MULT_FU_PERF_EN
  logic [31:0] perf_ops, perf_stall_cycles;
`endif

  always #5 clock = ~clock;

  mult_fu #(
    .XLEN(32), .NUM_STAGES(NS), .TAG_W(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .issue_valid(issue_valid),
    .opa(opa),
    .opb(opb),
    .func(func),
    .rob_tag(rob_tag),
    .squash(squash),
    .ack(ack),
    .ready(ready),
    .done(done),
    .result(result),
    .rob_tag_out(rob_tag_out)
`ifdef MULT_FU_PERF_EN
    ,
    .perf_ops(perf_ops),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // model: in-flight ops (NS-1 slots before the output register)
  bit          lv[NS-1];
  logic [4:0]  lt[NS-1];
  logic [31:0] lr[NS-1];
  bit          m_done;
  logic [4:0]  m_tag;
  logic [31:0] m_res;
  int          m_ops, m_stalls;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0]  f);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      2'd0, 2'd1: p = 64'(sa * sb);
      2'd2:       p = 64'(sa * ub);
      default:    p = 64'(ua * ub);
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS - 1; i++) lv[i] = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; issue_valid = 1'b0;
    squash = 1'b0; ack = 1'b0;
    opa = '0; opb = '0; func = '0; rob_tag = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    m_ops = 0; m_stalls = 0;
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_tag", rob_tag_out, 0);
    check("rst_ready", ready, 1);
  endtask

  task automatic cyc(input bit iv, input logic [31:0] a,
                     input logic [31:0] b, input logic [1:0] f,
                     input logic [4:0] t, input bit ak,
                     input bit sq, output bit acc);
    bit mr;
    issue_valid = iv; opa = a; opb = b; func = f;
    rob_tag = t; ack = ak; squash = sq;
    mr  = !(m_done && !ak);
    acc = iv && mr;
    #1;
    check("ready", ready, mr);
    @(posedge clock);
    if (iv && !mr) m_stalls++;
    if (acc) m_ops++;
    if (sq) begin
      model_clear();
    end else if (mr) begin
      m_done = lv[NS-2];
      m_tag  = lt[NS-2];
      m_res  = lr[NS-2];
      for (int i = NS - 2; i > 0; i--) begin
        lv[i] = lv[i-1]; lt[i] = lt[i-1]; lr[i] = lr[i-1];
      end
      lv[0] = acc; lt[0] = t; lr[0] = ref_mul(a, b, f);
    end
    #1;
    check("done", done, m_done);
    if (m_done) begin
      check("result", result, m_res);
      check("tag", rob_tag_out, m_tag);
    end
  endtask

  task automatic idle(input int n, input bit ak);
    bit acc;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, ak, 0, acc);
  endtask

  // issue one op, ack every cycle, check latency and constant result
  task automatic issue_wait(input string nm, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] f,
                            input logic [4:0] t, input logic [31:0] expv);
    bit acc;
    int w;
    cyc(1, a, b, f, t, 1, 0, acc);
    w = 0;
    while (!done && w < 12) begin
      cyc(0, 0, 0, 0, 0, 1, 0, acc);
      w++;
    end
    check({nm, "_lat"}, w, NS - 1);
    check({nm, "_res"}, result, expv);
    check({nm, "_tag"}, rob_tag_out, t);
  endtask

  initial begin
    bit acc;
    int nxt, seen, c;
    bit iv, ak, sq;
    logic [31:0] a, b;

    do_reset();

    // basic and high variants
    issue_wait("mul42", 7, 6, 0, 3, 42);
    issue_wait("mulh", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 4, 32'h0);
    issue_wait("mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 5, 32'hFFFF_FFFE);
    issue_wait("mulhsu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 6, 32'hFFFF_FFFF);
    issue_wait("mulm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 7, 32'h1);
    idle(2, 1);

    // back-pressure: tags 0..5, held until accepted, drained in order
    nxt = 0; seen = 0;
    for (c = 0; c < 80 && seen < 6; c++) begin
      ak = (c == 8) || (c >= 10 && (c % 2 == 0));
      if (done && ak) begin
        check("order", rob_tag_out, seen);
        seen++;
      end
      cyc(nxt < 6, $urandom, $urandom, 2'($urandom_range(0, 3)),
          5'(nxt), ak, 0, acc);
      if (acc) nxt++;
      if (c == 8) check("tag1_next", rob_tag_out, 1);
    end
    check("drained", seen, 6);
    idle(4, 1);

    // squash mid-flight; op presented with squash is dropped
    cyc(1, 11, 13, 0, 1, 1, 0, acc);
    cyc(1, 17, 19, 1, 2, 1, 0, acc);
    cyc(1, 23, 29, 3, 3, 1, 0, acc);
    cyc(1, 31, 37, 0, 9, 1, 1, acc);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0, acc);
      check("sq_done", done, 0);
      check("sq_ready", ready, 1);
    end
    issue_wait("post_sq", 32'hFFFF_FFFD, 9, 0, 12, 32'hFFFF_FFE5);

    // ack + squash together while done=1
    cyc(1, 5, 5, 0, 10, 0, 0, acc);
    cyc(1, 6, 6, 0, 11, 0, 0, acc);
    for (int i = 0; i < 10 && !done; i++) idle(1, 0);
    check("pre_acksq", done, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, acc);
    check("acksq_done", done, 0);
    for (int i = 0; i < 6; i++) begin
      idle(1, 1);
      check("acksq_quiet", done, 0);
    end

    // reset with ops in flight
    cyc(1, 100, 3, 0, 20, 1, 0, acc);
    cyc(1, 200, 3, 0, 21, 1, 0, acc);
    cyc(1, 300, 3, 0, 22, 1, 0, acc);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle(1, 1);
      check("rst_quiet", done, 0);
    end

    // random traffic
    for (int i = 0; i < 500; i++) begin
      iv = $urandom_range(0, 99) < 65;
      ak = $urandom_range(0, 99) < 75;
      sq = $urandom_range(0, 99) < 3;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 15) == 0) b = 32'h0;
      cyc(iv, a, b, 2'($urandom_range(0, 3)),
          5'($urandom), ak, sq, acc);
    end
    idle(6, 1);

`ifdef MULT_FU_PERF_EN
    do_reset();
    check("perf_rst_ops", perf_ops, 0);
    check("perf_rst_stall", perf_stall_cycles, 0);
    for (int i = 0; i < 40 && m_ops < 10; i++)
      cyc(1, $urandom, $urandom, 0, 5'(i), m_stalls >= 3, 0, acc);
    check("perf_ops", perf_ops, 10);
    check("perf_stall", perf_stall_cycles, 3);
    check("perf_ops_m", m_ops, 10);
    do_reset();
    check("perf_clr_ops", perf_ops, 0);
    check("perf_clr_stall", perf_stall_cycles, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
